// File: rtl/rv32_decode_pkg.sv
// Shared definitions for the RV32 decode stage: opcodes, format codes and
// the immediate assembly helper.
package rv32_decode_pkg;

    localparam int unsigned RegAddrWidthDef = 5;
    localparam int unsigned ExtImmWidthDef  = 32;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtInv = 3'd6
    } fmt_e;

    // 32-bit immediate for a given format; R and invalid carry no immediate.
    function automatic logic [31:0] imm_of(input fmt_e f, input logic [31:0] w);
        case (f)
            FmtI:    return {{20{w[31]}}, w[31:20]};
            FmtS:    return {{20{w[31]}}, w[31:25], w[11:7]};
            FmtB:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FmtU:    return {w[31:12], 12'h000};
            FmtJ:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I/RV32E decoder: instruction word to register
// indices, enables, sign-extended immediate, format and illegal flag.
module rv32_decode_comb
    import rv32_decode_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDef,
    parameter int unsigned EXT_IMM_WIDTH  = ExtImmWidthDef,
    parameter bit          RV32E          = 1'b0
) (
    input  logic [31:0]               inst_i,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic                      rs1_re_o,
    output logic                      rs2_re_o,
    output logic                      rd_we_o,
    output logic [EXT_IMM_WIDTH-1:0]  imm_o,
    output fmt_e                      fmt_o,
    output logic                      illegal_o
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    fmt_e       w_fmt;
    logic       w_legal;
    logic       w_use_rd;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_rd_we;
    logic       w_rs1_re;
    logic       w_rs2_re;

    assign w_opcode = inst_i[6:0];
    assign w_rd     = inst_i[11:7];
    assign w_funct3 = inst_i[14:12];
    assign w_rs1    = inst_i[19:15];
    assign w_rs2    = inst_i[24:20];
    assign w_funct7 = inst_i[31:25];

    always_comb begin
        w_fmt     = FmtInv;
        w_legal   = 1'b1;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OpLui, OpAuipc: begin
                w_fmt    = FmtU;
                w_use_rd = 1'b1;
            end
            OpJal: begin
                w_fmt    = FmtJ;
                w_use_rd = 1'b1;
            end
            OpJalr: begin
                w_fmt     = FmtI;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_legal   = (w_funct3 == 3'b000);
            end
            OpLoad: begin
                w_fmt     = FmtI;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_legal   = !(w_funct3 inside {3'b011, 3'b110, 3'b111});
            end
            OpImm: begin
                w_fmt     = FmtI;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                // Shift immediates reuse imm[11:5] as a funct7 qualifier.
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                end
            end
            OpMiscMem, OpSystem: begin
                w_fmt     = FmtI;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
            end
            OpBranch: begin
                w_fmt     = FmtB;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_legal   = !(w_funct3 inside {3'b010, 3'b011});
            end
            OpStore: begin
                w_fmt     = FmtS;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_legal   = (w_funct3 < 3'b011);
            end
            OpOp: begin
                w_fmt     = FmtR;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_legal   = (w_funct7 == 7'b0000000) ||
                            ((w_funct7 == 7'b0100000) &&
                             ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            default: w_legal = 1'b0;
        endcase
        if (w_opcode[1:0] != 2'b11) begin
            w_legal = 1'b0;
        end
        if (RV32E && ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1[4]) ||
                      (w_use_rs2 && w_rs2[4]))) begin
            w_legal = 1'b0;
        end
    end

    assign w_rs1_re = w_legal & w_use_rs1;
    assign w_rs2_re = w_legal & w_use_rs2;
    assign w_rd_we  = w_legal & w_use_rd & (w_rd != 5'd0);

    assign rs1_re_o   = w_rs1_re;
    assign rs2_re_o   = w_rs2_re;
    assign rd_we_o    = w_rd_we;
    assign rd_addr_o  = w_rd_we  ? w_rd[REG_ADDR_WIDTH-1:0]  : '0;
    assign rs1_addr_o = w_rs1_re ? w_rs1[REG_ADDR_WIDTH-1:0] : '0;
    assign rs2_addr_o = w_rs2_re ? w_rs2[REG_ADDR_WIDTH-1:0] : '0;
    assign fmt_o      = w_legal ? w_fmt : FmtInv;
    assign illegal_o  = !w_legal;
    assign imm_o      = w_legal ? EXT_IMM_WIDTH'($signed(imm_of(w_fmt, inst_i))) : '0;

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered decode stage with valid/ready on both sides, a main output
// register plus one skid entry, and a flush that empties both.
module rv32_decode_stage
    import rv32_decode_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDef,
    parameter int unsigned EXT_IMM_WIDTH  = ExtImmWidthDef,
    parameter int unsigned PC_WIDTH       = 32,
    parameter bit          RV32E          = 1'b0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [31:0]               inst_code_i,
    input  logic [PC_WIDTH-1:0]       pc_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [PC_WIDTH-1:0]       pc_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
    output logic                      rs1_re_o,
    output logic                      rs2_re_o,
    output logic                      rd_we_o,
    output logic [EXT_IMM_WIDTH-1:0]  imm_extend_o,
    output logic [2:0]                inst_fmt_o,
    output logic [2:0]                funct3_o,
    output logic                      funct7b5_o,
    output logic [6:0]                opcode_o,
    output logic                      illegal_o
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]       pc;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic                      rs1_re;
        logic                      rs2_re;
        logic                      rd_we;
        logic [EXT_IMM_WIDTH-1:0]  imm;
        logic [2:0]                fmt;
        logic [2:0]                funct3;
        logic                      funct7b5;
        logic [6:0]                opcode;
        logic                      illegal;
    } entry_t;

    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [REG_ADDR_WIDTH-1:0] w_rs1;
    logic [REG_ADDR_WIDTH-1:0] w_rs2;
    logic                      w_rs1_re;
    logic                      w_rs2_re;
    logic                      w_rd_we;
    logic [EXT_IMM_WIDTH-1:0]  w_imm;
    fmt_e                      w_fmt;
    logic                      w_illegal;
    entry_t                    w_dec;
    logic                      w_in_fire;

    entry_t r_main_q, r_main_d;
    entry_t r_skid_q, r_skid_d;
    logic   r_main_valid_q, r_main_valid_d;
    logic   r_skid_valid_q, r_skid_valid_d;
    logic   r_in_ready_q, r_in_ready_d;

    rv32_decode_comb #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .EXT_IMM_WIDTH  (EXT_IMM_WIDTH),
        .RV32E          (RV32E)
    ) u_decode_comb (
        .inst_i     (inst_code_i),
        .rd_addr_o  (w_rd),
        .rs1_addr_o (w_rs1),
        .rs2_addr_o (w_rs2),
        .rs1_re_o   (w_rs1_re),
        .rs2_re_o   (w_rs2_re),
        .rd_we_o    (w_rd_we),
        .imm_o      (w_imm),
        .fmt_o      (w_fmt),
        .illegal_o  (w_illegal)
    );

    assign w_dec = '{
        pc:       pc_i,
        rd:       w_rd,
        rs1:      w_rs1,
        rs2:      w_rs2,
        rs1_re:   w_rs1_re,
        rs2_re:   w_rs2_re,
        rd_we:    w_rd_we,
        imm:      w_imm,
        fmt:      w_fmt,
        funct3:   inst_code_i[14:12],
        funct7b5: inst_code_i[30],
        opcode:   inst_code_i[6:0],
        illegal:  w_illegal
    };

    assign w_in_fire = in_valid_i & r_in_ready_q;

    always_comb begin
        r_main_d       = r_main_q;
        r_skid_d       = r_skid_q;
        r_main_valid_d = r_main_valid_q;
        r_skid_valid_d = r_skid_valid_q;
        if (flush_i) begin
            r_main_valid_d = 1'b0;
            r_skid_valid_d = 1'b0;
        end else if (r_main_valid_q && !out_ready_i) begin
            // Output stalled: park the newcomer in the skid entry.
            if (w_in_fire) begin
                r_skid_d       = w_dec;
                r_skid_valid_d = 1'b1;
            end
        end else if (r_skid_valid_q) begin
            // in_ready is low whenever the skid is full, so no new word arrives here.
            r_main_d       = r_skid_q;
            r_main_valid_d = 1'b1;
            r_skid_valid_d = 1'b0;
        end else begin
            r_main_valid_d = w_in_fire;
            if (w_in_fire) begin
                r_main_d = w_dec;
            end
        end
        r_in_ready_d = !r_skid_valid_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main_q       <= '0;
            r_skid_q       <= '0;
            r_main_valid_q <= 1'b0;
            r_skid_valid_q <= 1'b0;
            r_in_ready_q   <= 1'b0;
        end else begin
            r_main_q       <= r_main_d;
            r_skid_q       <= r_skid_d;
            r_main_valid_q <= r_main_valid_d;
            r_skid_valid_q <= r_skid_valid_d;
            r_in_ready_q   <= r_in_ready_d;
        end
    end

    assign in_ready_o   = r_in_ready_q;
    assign out_valid_o  = r_main_valid_q;
    assign pc_o         = r_main_q.pc;
    assign rd_addr_o    = r_main_q.rd;
    assign rs1_addr_o   = r_main_q.rs1;
    assign rs2_addr_o   = r_main_q.rs2;
    assign rs1_re_o     = r_main_q.rs1_re;
    assign rs2_re_o     = r_main_q.rs2_re;
    assign rd_we_o      = r_main_q.rd_we;
    assign imm_extend_o = r_main_q.imm;
    assign inst_fmt_o   = r_main_q.fmt;
    assign funct3_o     = r_main_q.funct3;
    assign funct7b5_o   = r_main_q.funct7b5;
    assign opcode_o     = r_main_q.opcode;
    assign illegal_o    = r_main_q.illegal;

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage for the RV32 core: a generalised successor to the combinational decoder. It decodes all RV32I formats (R/I/S/B/U/J) plus an RV32E mode, and flags illegal encodings. It sits between fetch and register-file read/execute, uses valid/ready handshakes on both sides, and has a 2-entry skid buffer and a flush input.

Parameters:
REG_ADDR_WIDTH, 5, register index width (4 when RV32E=1)
EXT_IMM_WIDTH, 32, sign-extended immediate width, must be >=32
PC_WIDTH, 32, program-counter width carried alongside the instruction
RV32E, 0, 1 = registers x16..x31 are illegal

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
flush_i  input  1  discard all buffered instructions
in_valid_i  input  1  fetch offers an instruction
in_ready_o  output  1  stage accepts the instruction
inst_code_i  input  32  instruction word
pc_i  input  PC_WIDTH  PC of inst_code_i
out_valid_o  output  1  decoded instruction valid
out_ready_i  input  1  downstream accepts it
pc_o  output  PC_WIDTH  PC of the decoded instruction
rd_addr_o  output  REG_ADDR_WIDTH  destination register
rs1_addr_o  output  REG_ADDR_WIDTH  source register 1
rs2_addr_o  output  REG_ADDR_WIDTH  source register 2
rs1_re_o  output  1  rs1 read enable
rs2_re_o  output  1  rs2 read enable
rd_we_o  output  1  rd write enable
imm_extend_o  output  EXT_IMM_WIDTH  sign-extended immediate
inst_fmt_o  output  3  0=R 1=I 2=S 3=B 4=U 5=J 6=invalid
funct3_o  output  3  inst[14:12]
funct7b5_o  output  1  inst[30]
opcode_o  output  7  inst[6:0]
illegal_o  output  1  illegal or unsupported encoding

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low. While reset is asserted, every output register is 0 and in_ready_o=0. in_ready_o goes to 1 on the first clk edge after rstn deasserts.
- Handshakes: input transfer when in_valid_i&in_ready_o; output transfer when out_valid_o&out_ready_i. out_valid_o, once high, stays high with stable payload until the transfer completes.
- Latency: one cycle from input transfer to out_valid_o when the output register is empty. Throughput is 1 instruction/cycle while out_ready_i=1.
- Skid buffer: main register plus one skid register. in_ready_o is registered and equals !skid_valid.
  - Output register full and out_ready_i=0: an accepted instruction goes to the skid register.
  - When the output drains, skid contents move to the main register.
  - Order is always preserved; no instruction is lost or duplicated.
- Flush: flush_i=1 clears both valid bits on the next edge, and the input transfer in the same cycle is dropped. An output transfer in the same cycle is still considered completed. The next cycle has in_ready_o=1 and out_valid_o=0.
- Decode is combinational on the incoming word; results are stored with the entry.
- Formats by opcode:
  - LUI 0110111 and AUIPC 0010111: U
  - JAL 1101111: J
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011: I
  - BRANCH 1100011: B
  - STORE 0100011: S
  - OP 0110011: R
- Immediates: standard RISC-V bit assembly, sign-extended from bit 31 to EXT_IMM_WIDTH.
  - U: imm[31:12], low 12 bits zero.
  - R format and illegal: imm=0.
- Read/write enables:
  - rs1_re_o=1 for R/I/S/B, except LUI/AUIPC/JAL.
  - rs2_re_o=1 for R/S/B.
  - rd_we_o=1 for R/I/U/J except STORE/BRANCH, and forced 0 when rd=x0.
- Address outputs: an address whose enable is 0 is output as 0.
- Illegal (illegal_o=1, inst_fmt_o=6, all enables 0, imm 0):
  - inst[1:0]!=11
  - unknown opcode
  - OP with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101}
  - OP-IMM shift with bad funct7
  - BRANCH funct3 010/011
  - LOAD funct3 011/110/111
  - STORE funct3 >=011
  - JALR funct3!=000
  - RV32E=1 and any used register index >=16
- Illegal instructions still flow through the stage so the exception is precise.
- Reset mid-operation clears all entries asynchronously; pending instructions are discarded.

Decomposition:
- Opcode constants, format codes (FMT_R..FMT_INV) and REG_ADDR_WIDTH/EXT_IMM_WIDTH defaults go in the shared macros/rv32_define.vh header.
- One natural sub-module: rv32_decode_comb, the pure combinational decoder (word -> decoded bundle, parameters REG_ADDR_WIDTH/EXT_IMM_WIDTH/RV32E).
- rv32_decode_stage instantiates it and holds the skid/handshake logic.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle: out_valid=1, fmt=1, rd=1, rs1=2, rs1_re=1, rs2_re=0, rd_we=1, imm=0xFFFFFFFF.
- SW x5,8(x6) (0x00532423) -> fmt=2, rs1=6, rs2=5, both re=1, rd_we=0, rd_addr=0, imm=8.
- BEQ x0,x0,-4 (0xFE000EE3) -> fmt=3, imm=0xFFFFFFFC, rd_we=0. Then ADDI x0,x0,0 (0x00000013) -> rd_we=0.
- Backpressure: out_ready=0, push A, B back-to-back -> in_ready=0 after B. Raise out_ready -> A then B delivered in order, in_ready=1 again.
- RV32E=1, ADD x16,x1,x2 (0x00208833) -> illegal_o=1, fmt=6, all enables 0. With RV32E=0 -> legal R, rd=16.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears. Asserting rstn=0 mid-stream -> all outputs 0 immediately.
